// File: rtl/warp_ibuf.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular queue that accepts
// up to two instructions per cycle and presents up to two to decode.
module warp_ibuf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic [31:0] i_inst0,
    input  logic [31:0] i_inst1,
    input  logic [63:0] i_inst0_pc,
    input  logic [63:0] i_inst1_pc,
    input  logic [1:0]  i_compressed,
    input  logic [1:0]  i_valid,
    output logic        o_stall,
    input  logic        i_stall,
    output logic [31:0] o_inst0,
    output logic [31:0] o_inst1,
    output logic [63:0] o_inst0_pc,
    output logic [63:0] o_inst1_pc,
    output logic [1:0]  o_compressed,
    output logic [1:0]  o_valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] CANONICAL_NOP = 32'h0000_0013;
    // Stall once fewer than two free entries remain, so a dual push always fits.
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(DEPTH - 2);

    logic [31:0]      inst_mem [DEPTH];
    logic [63:0]      pc_mem   [DEPTH];
    logic [DEPTH-1:0] comp_mem;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_en;
    logic             pop_en;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [PTR_W-1:0] wr_ptr0;
    logic [PTR_W-1:0] wr_ptr1;
    logic [PTR_W-1:0] rd_ptr0;
    logic [PTR_W-1:0] rd_ptr1;

    assign o_stall = (count_q > STALL_LIMIT);
    assign push_en = !o_stall && !i_flush;
    assign pop_en  = !i_stall && !i_flush;

    assign wr_ptr0 = tail_q;
    assign wr_ptr1 = tail_q + PTR_W'(i_valid[0]);
    assign rd_ptr0 = head_q;
    assign rd_ptr1 = head_q + PTR_W'(1);

    always_comb begin
        push_n = 2'd0;
        if (push_en) begin
            push_n = {1'b0, i_valid[0]} + {1'b0, i_valid[1]};
        end
    end

    always_comb begin
        o_valid = 2'b00;
        if (!i_flush) begin
            if (count_q >= CNT_W'(2)) begin
                o_valid = 2'b11;
            end else if (count_q == CNT_W'(1)) begin
                o_valid = 2'b01;
            end
        end
    end

    always_comb begin
        pop_n = 2'd0;
        if (pop_en) begin
            pop_n = {1'b0, o_valid[0]} + {1'b0, o_valid[1]};
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(push_n);
            count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_en && i_valid[0]) begin
            inst_mem[wr_ptr0] <= i_inst0;
            pc_mem[wr_ptr0]   <= i_inst0_pc;
            comp_mem[wr_ptr0] <= i_compressed[0];
        end
        if (push_en && i_valid[1]) begin
            inst_mem[wr_ptr1] <= i_inst1;
            pc_mem[wr_ptr1]   <= i_inst1_pc;
            comp_mem[wr_ptr1] <= i_compressed[1];
        end
    end

    always_comb begin
        o_inst0      = o_valid[0] ? inst_mem[rd_ptr0] : CANONICAL_NOP;
        o_inst1      = o_valid[1] ? inst_mem[rd_ptr1] : CANONICAL_NOP;
        o_inst0_pc   = pc_mem[rd_ptr0];
        o_inst1_pc   = pc_mem[rd_ptr1];
        o_compressed = {o_valid[1] & comp_mem[rd_ptr1], o_valid[0] & comp_mem[rd_ptr0]};
    end

endmodule

// File: tb/tb_warp_ibuf.sv
// Scoreboard bench for warp_ibuf: a queue model of accepted instructions is compared against
// the decode-side outputs every cycle under directed and random fetch/decode/flush traffic.
module tb_warp_ibuf;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_flush;
    logic [31:0] i_inst0, i_inst1;
    logic [63:0] i_inst0_pc, i_inst1_pc;
    logic [1:0]  i_compressed, i_valid;
    logic        o_stall;
    logic        i_stall;
    logic [31:0] o_inst0, o_inst1;
    logic [63:0] o_inst0_pc, o_inst1_pc;
    logic [1:0]  o_compressed, o_valid;

    warp_ibuf #(.DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_inst0      (i_inst0),
        .i_inst1      (i_inst1),
        .i_inst0_pc   (i_inst0_pc),
        .i_inst1_pc   (i_inst1_pc),
        .i_compressed (i_compressed),
        .i_valid      (i_valid),
        .o_stall      (o_stall),
        .i_stall      (i_stall),
        .o_inst0      (o_inst0),
        .o_inst1      (o_inst1),
        .o_inst0_pc   (o_inst0_pc),
        .o_inst1_pc   (o_inst1_pc),
        .o_compressed (o_compressed),
        .o_valid      (o_valid)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        c;
    } ent_t;

    ent_t        q[$];     // entries the DUT holds right now
    ent_t        pend[$];  // entries accepted this cycle, enter the queue at the next edge
    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [63:0] next_pc;
    int          n;
    logic [1:0]  exp_v;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_o_valid", 64'(o_valid), 64'(2'b00));
        chk("rst_o_stall", 64'(o_stall), 64'(1'b0));
        chk("rst_o_inst0", 64'(o_inst0), 64'(NOP));
        chk("rst_o_inst1", 64'(o_inst1), 64'(NOP));
        chk("rst_o_compressed", 64'(o_compressed), 64'(2'b00));
    endtask

    // One fetch/decode cycle; acceptance is predicted from the model's occupancy.
    task automatic drive(input logic [1:0] v, input logic st, input logic fl);
        ent_t e0, e1;
        @(posedge i_clk);
        while (pend.size() > 0) q.push_back(pend.pop_front());
        #1;
        e0.inst = $urandom;
        e0.pc   = next_pc;
        e0.c    = 1'($urandom_range(0, 1));
        e1.inst = $urandom;
        e1.pc   = next_pc + 64'd4;
        e1.c    = 1'($urandom_range(0, 1));
        next_pc = next_pc + 64'd8;
        i_inst0      = e0.inst;
        i_inst1      = e1.inst;
        i_inst0_pc   = e0.pc;
        i_inst1_pc   = e1.pc;
        i_compressed = {e1.c, e0.c};
        i_valid      = v;
        i_stall      = st;
        i_flush      = fl;
        if (!fl && q.size() <= int'(DEPTH) - 2) begin
            if (v[0]) pend.push_back(e0);
            if (v[1]) pend.push_back(e1);
        end
    endtask

    task automatic pulse_reset();
        @(posedge i_clk);
        while (pend.size() > 0) q.push_back(pend.pop_front());
        #1;
        i_rst_n = 1'b0;
        i_valid = 2'b00;
        i_flush = 1'b0;
        q.delete();
        pend.delete();
        #1;
        check_reset_outputs();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    always @(negedge i_clk) begin
        if (mon_en && i_rst_n) begin
            n = q.size();
            exp_v = i_flush ? 2'b00 : (n == 0 ? 2'b00 : (n == 1 ? 2'b01 : 2'b11));
            chk("o_stall", 64'(o_stall), 64'(n > int'(DEPTH) - 2));
            chk("o_valid", 64'(o_valid), 64'(exp_v));
            chk("o_valid_not_10", 64'(o_valid == 2'b10), 64'(1'b0));
            if (exp_v[0]) begin
                chk("slot0_inst", 64'(o_inst0), 64'(q[0].inst));
                chk("slot0_pc", o_inst0_pc, q[0].pc);
                chk("slot0_c", 64'(o_compressed[0]), 64'(q[0].c));
            end else begin
                chk("slot0_nop", 64'(o_inst0), 64'(NOP));
                chk("slot0_c_masked", 64'(o_compressed[0]), 64'(1'b0));
            end
            if (exp_v[1]) begin
                chk("slot1_inst", 64'(o_inst1), 64'(q[1].inst));
                chk("slot1_pc", o_inst1_pc, q[1].pc);
                chk("slot1_c", 64'(o_compressed[1]), 64'(q[1].c));
            end else begin
                chk("slot1_nop", 64'(o_inst1), 64'(NOP));
                chk("slot1_c_masked", 64'(o_compressed[1]), 64'(1'b0));
            end
            if (i_flush) begin
                q.delete();
            end else if (!i_stall) begin
                if (exp_v[0]) void'(q.pop_front());
                if (exp_v[1]) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [1:0] v;
        i_rst_n      = 1'b0;
        i_flush      = 1'b0;
        i_stall      = 1'b0;
        i_valid      = 2'b00;
        i_compressed = 2'b00;
        i_inst0      = '0;
        i_inst1      = '0;
        i_inst0_pc   = '0;
        i_inst1_pc   = '0;
        next_pc      = 64'h8000_0000_0000_0000;
        #12;
        check_reset_outputs();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Dual push from empty while decode stalls
        drive(2'b11, 1'b1, 1'b0);
        repeat (2) drive(2'b00, 1'b1, 1'b0);
        // Fill to DEPTH, drop a push while full, then drain in order
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b00, 1'b1, 1'b0);
        repeat (4) drive(2'b00, 1'b0, 1'b0);
        // Odd occupancy and pointer wrap
        for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 1'b0, 1'b0);
        // Flush at count 3 with a simultaneous push
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b1);
        repeat (2) drive(2'b00, 1'b0, 1'b0);
        // Asynchronous reset with two entries held
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b00, 1'b1, 1'b0);
        pulse_reset();
        repeat (2) drive(2'b00, 1'b0, 1'b0);
        // Full throughput
        repeat (12) drive(2'b11, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 2))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                drive(v, ($urandom_range(0, 9) < 3), ($urandom_range(0, 24) == 0));
            end
        end
        repeat (4) drive(2'b00, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
